// File: rtl/register_write_arbiter.sv
// register_write_arbiter
//   Shares one WIDTH-bit flip-flop bank (D, CE, PRE pins) between NUM_REQ
//   write requesters using a request/acknowledge handshake per requester.
//   Sequence: INIT (preset held PRESET_CYCLES cycles) -> IDLE -> GRANT ->
//   WRITE (one CE cycle) -> ACK (one-cycle acknowledge) -> IDLE.
//   All outputs are registered; there is no combinational request-to-output path.
//
// Ports
//   clock               rising-edge system clock
//   input_reset         synchronous, active-high reset
//   input_request       per-requester level request, held until acknowledge
//   input_data          requester i data in bits [i*WIDTH +: WIDTH]
//   output_grant        one-hot grant, high during GRANT and WRITE
//   output_acknowledge  one-cycle pulse to the served requester
//   output_register_d   flip-flop bank D pins (last latched data)
//   output_clock_enable flip-flop bank CE pins, high only during WRITE
//   output_preset       flip-flop bank PRE pins, high during INIT
//   output_busy         high in every state except IDLE
//
// Build option
//   ARBITER_FIXED_PRIORITY_EN : lowest index always wins; the round-robin
//   pointer stays at its reset value. Undefined: round-robin arbitration.

module register_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 8,
  parameter int PRESET_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     input_reset,
  input  logic [NUM_REQ-1:0]       input_request,
  input  logic [NUM_REQ*WIDTH-1:0] input_data,
  output logic [NUM_REQ-1:0]       output_grant,
  output logic [NUM_REQ-1:0]       output_acknowledge,
  output logic [WIDTH-1:0]         output_register_d,
  output logic                     output_clock_enable,
  output logic                     output_preset,
  output logic                     output_busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PRESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_GRANT,
    S_WRITE,
    S_ACK
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 ce_q, ce_d;
  logic                 preset_q, preset_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [PW-1:0]        win_idx;
  int unsigned          idx;

  // Search starts one past the pointer and wraps, so the last winner has
  // lowest priority. In fixed-priority mode the pointer stays at NUM_REQ-1,
  // which makes the same search start at index 0.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && input_request[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    win_d   = win_q;

    case (state_q)
      S_INIT: begin
        if (cnt_q == CW'(PRESET_CYCLES - 1)) state_d = S_IDLE;
        else                                  cnt_d   = cnt_q + CW'(1);
      end
      S_IDLE: begin
        if (found) begin
          data_d         = input_data[32'(win_idx)*WIDTH +: WIDTH];
          win_d          = '0;
          win_d[win_idx] = 1'b1;
`ifndef ARBITER_FIXED_PRIORITY_EN
          ptr_d          = win_idx;
`endif
          state_d        = S_GRANT;
        end
      end
      S_GRANT: begin
        if (|(input_request & win_q)) state_d = S_WRITE;
        else                          state_d = S_IDLE;
      end
      S_WRITE: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the state does.
    grant_d  = (state_d == S_GRANT || state_d == S_WRITE) ? win_d : '0;
    ack_d    = (state_d == S_ACK) ? win_d : '0;
    ce_d     = (state_d == S_WRITE);
    preset_d = (state_d == S_INIT);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (input_reset) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      ptr_q    <= PW'(NUM_REQ - 1);
      data_q   <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      ce_q     <= 1'b0;
      preset_q <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      ce_q     <= ce_d;
      preset_q <= preset_d;
      busy_q   <= busy_d;
    end
  end

  assign output_grant        = grant_q;
  assign output_acknowledge  = ack_q;
  assign output_register_d   = data_q;
  assign output_clock_enable = ce_q;
  assign output_preset       = preset_q;
  assign output_busy         = busy_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Testbench for register_write_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_register_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic [W-1:0]     regd;
  logic             ce;
  logic             preset;
  logic             busy;

  int n_cmp;
  int n_err;

  // model state: rotation pointer and last latched data
  int               m_ptr;
  logic [W-1:0]     m_regd;

  register_write_arbiter #(
    .NUM_REQ(N),
    .WIDTH(W),
    .PRESET_CYCLES(P)
  ) dut (
    .clock(clk),
    .input_reset(rst),
    .input_request(req),
    .input_data(data),
    .output_grant(grant),
    .output_acknowledge(ack),
    .output_register_d(regd),
    .output_clock_enable(ce),
    .output_preset(preset),
    .output_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_winner(input logic [N-1:0] r, input int ptr);
    int i;
`ifdef ARBITER_FIXED_PRIORITY_EN
    for (i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      i = (ptr + k) % N;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk_outs(input string tag, input logic [N-1:0] g, input logic [N-1:0] a,
                          input logic c, input logic p, input logic b);
    chk({tag, ".grant"},  32'(grant),  32'(g));
    chk({tag, ".ack"},    32'(ack),    32'(a));
    chk({tag, ".ce"},     32'(ce),     32'(c));
    chk({tag, ".preset"}, 32'(preset), 32'(p));
    chk({tag, ".busy"},   32'(busy),   32'(b));
    chk({tag, ".regd"},   32'(regd),   32'(m_regd));
  endtask

  // Called with reset already asserted across one edge: drops reset and
  // checks preset stays high for exactly P cycles, requests ignored.
  task automatic release_reset(input logic [N-1:0] req_during);
    req    = req_during;
    rst    = 1'b0;
    m_ptr  = N - 1;
    m_regd = '0;
    for (int i = 1; i < P; i++) begin
      tick();
      chk_outs("init_hold", '0, '0, 1'b0, 1'b1, 1'b1);
    end
    req = '0;
    tick();
    chk_outs("init_done", '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [N-1:0] req_during);
    rst = 1'b1;
    req = req_during;
    tick();
    m_regd = '0;
    chk_outs("reset", '0, '0, 1'b0, 1'b1, 1'b1);
    release_reset(req_during);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
  endtask

  // mode: 0 normal, 1 drop in GRANT, 2 reset in GRANT, 3 reset in WRITE,
  //       4 drop after WRITE (acknowledge still expected)
  task automatic run_txn(input logic [N-1:0] r, input int mode);
    int w;
    w   = exp_winner(r, m_ptr);
    req = r;
    tick();
    m_regd = data[w*W +: W];
`ifndef ARBITER_FIXED_PRIORITY_EN
    m_ptr = w;
`endif
    chk_outs("grant", onehot(w), '0, 1'b0, 1'b0, 1'b1);
    if (mode == 1) begin
      req[w] = 1'b0;
      tick();
      chk_outs("abort", '0, '0, 1'b0, 1'b0, 1'b0);
      return;
    end
    if (mode == 2) begin
      rst = 1'b1;
      tick();
      m_regd = '0;
      chk_outs("rst_in_grant", '0, '0, 1'b0, 1'b1, 1'b1);
      release_reset('0);
      return;
    end
    req = req ^ 4'(($urandom & 32'hF) & ~(32'(1) << w));
    tick();
    chk_outs("write", onehot(w), '0, 1'b1, 1'b0, 1'b1);
    if (mode == 3) begin
      rst = 1'b1;
      tick();
      m_regd = '0;
      chk_outs("rst_in_write", '0, '0, 1'b0, 1'b1, 1'b1);
      release_reset('0);
      return;
    end
    if (mode == 4) req[w] = 1'b0;
    tick();
    chk_outs("ack", '0, onehot(w), 1'b0, 1'b0, 1'b1);
    req[w] = 1'b0;
    tick();
    chk_outs("idle", '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int r;
    logic [N-1:0] rv;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    req    = '0;
    data   = '0;
    m_ptr  = N - 1;
    m_regd = '0;
    tick();

    // reset with all requesting during INIT
    do_reset(4'b1111);

    // idle with no request stays idle
    req = '0;
    tick();
    chk_outs("no_req", '0, '0, 1'b0, 1'b0, 1'b0);

    // single request from requester 2
    rand_data();
    data[2*W +: W] = 8'hA5;
    run_txn(4'b0100, 0);

    // all four continuously with distinct data
    do_reset('0);
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0);

    // request 1 drops in GRANT, then requester 3 served with its own data
    rand_data();
    run_txn(4'b0010, 1);
    run_txn(4'b1000, 0);

    // reset during GRANT and during WRITE
    run_txn(4'b0001, 2);
    run_txn(4'b0100, 3);

    // wrap: serve 3 then 0 wins over 3
    run_txn(4'b1000, 0);
    run_txn(4'b1001, 0);

    // request dropped after WRITE still acknowledged
    run_txn(4'b0010, 4);

    // randomized transactions
    for (int i = 0; i < 80; i++) begin
      rand_data();
      rv = 4'($urandom_range(1, 15));
      r  = $urandom_range(0, 9);
      if      (r <= 5) run_txn(rv, 0);
      else if (r == 6) run_txn(rv, 1);
      else if (r == 7) run_txn(rv, 4);
      else if (r == 8) run_txn(rv, 2);
      else             run_txn(rv, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
